// File: rtl/vpu_dst_wb_buffer_pkg.sv
// Shared constants and types for the VPU destination write-back buffer.
package vpu_dst_wb_buffer_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 16;
  localparam int unsigned SRAM_ADDR_WIDTH = 16;
  localparam int unsigned VPU_LANES       = 32;
  localparam int unsigned VPU_WB_DEPTH    = 4;
  localparam int unsigned WB_CNT_WIDTH    = 16;

  // One queued write: destination address plus full result vector.
  typedef struct packed {
    logic [SRAM_ADDR_WIDTH-1:0]           addr;
    logic [SRAM_DATA_WIDTH*VPU_LANES-1:0] data;
  } vpu_wb_entry_t;

  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } vpu_wb_state_t;

endpackage

// File: rtl/vpu_wb_fifo.sv
// Small synchronous FIFO holding pending write-back entries.
module vpu_wb_fifo #(
  parameter int unsigned WIDTH = 528,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_data,
  output logic [WIDTH-1:0]           o_head_c,
  output logic [$clog2(DEPTH):0]     o_occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;

  // Storage array; contents are meaningless until written so it has no reset.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally; occupancy distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head_c    = r_mem[r_rd_ptr];
  assign o_occupancy = r_occ;

endmodule

// File: rtl/vpu_dst_wb_buffer.sv
// Write-back buffer between the VPU result stage and SRAM write port 0.
module vpu_dst_wb_buffer
  import vpu_dst_wb_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH * VPU_LANES,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = VPU_WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_data,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  output logic                      wr_req,
  output logic [ADDR_WIDTH-1:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  input  logic                      wr_ack,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic                      idle,
  output logic [WB_CNT_WIDTH-1:0]   wr_cnt
);

  localparam int unsigned OCC_W   = $clog2(DEPTH) + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  vpu_wb_state_t          r_state;
  vpu_wb_state_t          w_state_next;
  logic [WB_CNT_WIDTH-1:0] r_wr_cnt;
  logic [OCC_W-1:0]       w_occ;
  logic [OCC_W-1:0]       w_occ_next;
  logic [ENTRY_W-1:0]     w_head;
  logic                   w_push;
  logic                   w_pop;

  // Handshakes: accept when not full, retire the head on an ack while writing.
  assign in_ready   = (w_occ != OCC_W'(DEPTH));
  assign w_push     = in_valid && in_ready;
  assign w_pop      = (r_state == WB_WRITE) && wr_ack;
  assign w_occ_next = w_occ + OCC_W'(w_push) - OCC_W'(w_pop);

  vpu_wb_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_data      ({in_addr, in_data}),
    .o_head_c    (w_head),
    .o_occupancy (w_occ)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= WB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: start writing once anything is queued, stay while entries remain.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      WB_IDLE: begin
        if (w_occ != '0) begin
          w_state_next = WB_WRITE;
        end
      end
      WB_WRITE: begin
        if (wr_ack && (w_occ_next == '0)) begin
          w_state_next = WB_IDLE;
        end
      end
      default: w_state_next = WB_IDLE;
    endcase
  end

  // Completed-write counter; wraps naturally at the top of its range.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_cnt <= '0;
    end else if (w_pop) begin
      r_wr_cnt <= r_wr_cnt + WB_CNT_WIDTH'(1);
    end
  end

  // Write port driven from the FIFO head, forced to zero while no request is up.
  assign wr_req    = (r_state == WB_WRITE);
  assign wr_addr   = wr_req ? w_head[ENTRY_W-1:DATA_WIDTH] : '0;
  assign wr_data   = wr_req ? w_head[DATA_WIDTH-1:0]       : '0;
  assign occupancy = w_occ;
  assign idle      = (r_state == WB_IDLE) && (w_occ == '0);
  assign wr_cnt    = r_wr_cnt;

endmodule

// File: tb/tb_vpu_dst_wb_buffer.sv
// Directed self-checking bench for the VPU write-back buffer.
module tb_vpu_dst_wb_buffer;

  localparam int unsigned DW = 512;
  localparam int unsigned AW = 16;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [AW-1:0] in_addr;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [2:0]    occupancy;
  logic          idle;
  logic [15:0]   wr_cnt;

  int checks = 0;
  int errors = 0;

  vpu_dst_wb_buffer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_addr   (in_addr),
    .wr_req    (wr_req),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_ack    (wr_ack),
    .occupancy (occupancy),
    .idle      (idle),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] rep(input logic [15:0] v);
    return {32{v}};
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_addr  = '0;
    wr_ack   = 1'b0;
    step();
    step();
    chk("rst_wr_req", 512'(wr_req), 512'(0));
    chk("rst_in_ready", 512'(in_ready), 512'(1));
    chk("rst_idle", 512'(idle), 512'(1));
    chk("rst_occ", 512'(occupancy), 512'(0));
    chk("rst_cnt", 512'(wr_cnt), 512'(0));
    chk("rst_wr_addr", 512'(wr_addr), 512'(0));
    rst = 1'b0;
    step();

    // Single write with ack held high.
    in_valid = 1'b1;
    in_addr  = 16'h0010;
    in_data  = rep(16'h3C00);
    wr_ack   = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_occ1", 512'(occupancy), 512'(1));
    chk("single_req_lat", 512'(wr_req), 512'(0));
    step();
    chk("single_req", 512'(wr_req), 512'(1));
    chk("single_addr", 512'(wr_addr), 512'(16'h0010));
    chk("single_data", wr_data, rep(16'h3C00));
    step();
    chk("single_req_off", 512'(wr_req), 512'(0));
    chk("single_cnt", 512'(wr_cnt), 512'(1));
    chk("single_idle", 512'(idle), 512'(1));
    step();
    chk("single_req_once", 512'(wr_req), 512'(0));

    // Back-to-back: seven pushes on consecutive cycles, ack always high.
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_addr  = 16'(i);
      in_data  = rep(16'(i));
      chk("b2b_ready", 512'(in_ready), 512'(1));
      step();
      if (i == 0) begin
        chk("b2b_req_lat", 512'(wr_req), 512'(0));
      end else begin
        chk("b2b_req", 512'(wr_req), 512'(1));
        chk("b2b_addr", 512'(wr_addr), 512'(i - 1));
        chk("b2b_data", wr_data, rep(16'(i - 1)));
      end
    end
    in_valid = 1'b0;
    step();
    chk("b2b_req_last", 512'(wr_req), 512'(1));
    chk("b2b_addr_last", 512'(wr_addr), 512'(6));
    step();
    chk("b2b_req_off", 512'(wr_req), 512'(0));
    chk("b2b_cnt", 512'(wr_cnt), 512'(8));
    chk("b2b_idle", 512'(idle), 512'(1));

    // Backpressure: fill the buffer with ack low, fifth entry held by producer.
    wr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_addr  = 16'h0100 + 16'(i);
      in_data  = rep(16'h0A00 + 16'(i));
      step();
    end
    chk("bp_occ_full", 512'(occupancy), 512'(4));
    chk("bp_not_ready", 512'(in_ready), 512'(0));
    in_addr = 16'h0104;
    in_data = rep(16'h0A04);
    step();
    step();
    chk("bp_occ_hold", 512'(occupancy), 512'(4));
    chk("bp_req_hold", 512'(wr_req), 512'(1));
    chk("bp_addr_stable", 512'(wr_addr), 512'(16'h0100));
    wr_ack = 1'b1;
    step();
    chk("bp_ready_back", 512'(in_ready), 512'(1));
    chk("bp_occ_pop", 512'(occupancy), 512'(3));
    chk("bp_addr1", 512'(wr_addr), 512'(16'h0101));
    step();
    in_valid = 1'b0;
    chk("bp_occ_pushpop", 512'(occupancy), 512'(3));
    chk("bp_addr2", 512'(wr_addr), 512'(16'h0102));
    step();
    chk("bp_addr3", 512'(wr_addr), 512'(16'h0103));
    step();
    chk("bp_addr4", 512'(wr_addr), 512'(16'h0104));
    chk("bp_data4", wr_data, rep(16'h0A04));
    step();
    chk("bp_req_off", 512'(wr_req), 512'(0));
    chk("bp_cnt", 512'(wr_cnt), 512'(13));

    // Simultaneous push and pop at occupancy 2.
    wr_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_addr  = 16'h0200 + 16'(i);
      in_data  = rep(16'h0200 + 16'(i));
      step();
    end
    chk("pp_occ2", 512'(occupancy), 512'(2));
    chk("pp_head0", 512'(wr_addr), 512'(16'h0200));
    in_addr = 16'h0202;
    in_data = rep(16'h0202);
    wr_ack  = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pp_occ_same", 512'(occupancy), 512'(2));
    chk("pp_head1", 512'(wr_addr), 512'(16'h0201));
    chk("pp_data1", wr_data, rep(16'h0201));
    step();
    chk("pp_head2", 512'(wr_addr), 512'(16'h0202));
    step();
    chk("pp_idle", 512'(idle), 512'(1));
    chk("pp_cnt", 512'(wr_cnt), 512'(16));

    // Asynchronous reset in the middle of an outstanding write.
    wr_ack   = 1'b0;
    in_valid = 1'b1;
    in_addr  = 16'h0300;
    in_data  = rep(16'h0300);
    step();
    in_valid = 1'b0;
    step();
    chk("mid_req_up", 512'(wr_req), 512'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_req", 512'(wr_req), 512'(0));
    chk("mid_rst_ready", 512'(in_ready), 512'(1));
    chk("mid_rst_idle", 512'(idle), 512'(1));
    chk("mid_rst_occ", 512'(occupancy), 512'(0));
    chk("mid_rst_cnt", 512'(wr_cnt), 512'(0));
    step();
    rst = 1'b0;
    step();

    // Ack while idle must not count or pop.
    wr_ack = 1'b1;
    step();
    step();
    step();
    chk("ack_idle_cnt", 512'(wr_cnt), 512'(0));
    chk("ack_idle_req", 512'(wr_req), 512'(0));
    chk("ack_idle_occ", 512'(occupancy), 512'(0));

    // Counter wrap: 65535 writes, then one more.
    for (int i = 0; i < 65535; i++) begin
      in_valid = 1'b1;
      in_addr  = 16'(i);
      in_data  = rep(16'(i));
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 10 && !idle; k++) step();
    chk("wrap_drain_idle", 512'(idle), 512'(1));
    chk("wrap_ffff", 512'(wr_cnt), 512'(16'hFFFF));
    in_valid = 1'b1;
    in_addr  = 16'hBEEF;
    in_data  = rep(16'hBEEF);
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_last_addr", 512'(wr_addr), 512'(16'hBEEF));
    for (int k = 0; k < 10 && !idle; k++) step();
    chk("wrap_idle", 512'(idle), 512'(1));
    chk("wrap_zero", 512'(wr_cnt), 512'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vpu_dst_wb_buffer.md
# vpu_dst_wb_buffer

Write-back buffer directly downstream of the VPU datapath result stage, between the VPU destination port and SRAM write port 0. Accepts 512-bit result vectors with target addresses over a valid/ready handshake. Queues them in a small FIFO and drains them to SRAM with a req/ack write protocol, so SRAM write stalls do not stall the VPU pipeline until the buffer fills. Reports occupancy, idle and a completed-write count for the VPU controller.

## Interface
Parameters:
- DATA_WIDTH, 512, result vector / SRAM word width (VPU_PKG::SRAM_DATA_WIDTH × 32 lanes)
- ADDR_WIDTH, 16, SRAM word address width
- DEPTH, 4, FIFO entries; power of two, ≥2

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  result vector valid
- in_ready  output  1  buffer can accept an entry
- in_data  input  DATA_WIDTH  result vector
- in_addr  input  ADDR_WIDTH  destination SRAM address
- wr_req  output  1  SRAM write request
- wr_addr  output  ADDR_WIDTH  write address (FIFO head)
- wr_data  output  DATA_WIDTH  write data (FIFO head)
- wr_ack  input  1  SRAM accepted current write
- occupancy  output  $clog2(DEPTH)+1  entries held, including the one being written
- idle  output  1  FIFO empty and no write outstanding
- wr_cnt  output  16  completed writes, wraps 0xFFFF→0

## Operation
- Push: in_valid && in_ready at a rising edge stores {in_addr, in_data} at wr_ptr and increments occupancy.
- in_ready = (occupancy != DEPTH). It depends only on registered occupancy. There is no combinational path from wr_ack or in_valid.
- FSM states:
  - IDLE: wr_req=0. Go to WRITE at the next edge if occupancy ≠ 0 at that edge.
  - WRITE: wr_req=1, wr_addr/wr_data = head entry, held stable until an edge with wr_ack=1.
    - On that edge: pop head, wr_cnt+1.
    - If occupancy after pop/push ≠ 0, stay in WRITE and present the next head (back-to-back).
    - Otherwise go to IDLE.
- wr_ack while wr_req=0 is ignored; no pop, no count.
- Simultaneous push and pop at one edge: occupancy unchanged. This is legal even when full, but in_ready was already 0, so no push occurs when full.
- Pointers are log2(DEPTH) bits and wrap naturally. occupancy tracks full/empty.
- idle = (state==IDLE) && (occupancy==0).
- in_valid with in_ready=0: entry not taken; the producer must hold it.
- Reset values: wr_req=0, occupancy=0, in_ready=1, idle=1, wr_cnt=0, state=IDLE, pointers=0. wr_addr/wr_data are don't-care while wr_req=0 (drive 0 out of reset).
- Reset mid-write: all entries and the outstanding request are discarded immediately (asynchronous). SRAM must ignore a dropped request.

## Timing
- Push at edge N → occupancy=1 after N. wr_req rises after edge N+1 (minimum 1-cycle input-to-request latency).
- With wr_ack tied high: one write retired per cycle, sustained throughput 1 vector/cycle.
- Full buffer: in_ready returns to 1 the cycle after the edge where the pop occurs.
- wr_cnt and occupancy update on the same edge as the pop.

## Structure
- VPU_PKG additions: VPU_WB_DEPTH constant, vpu_wb_entry_t struct {addr, data}, vpu_wb_state_t enum {WB_IDLE, WB_WRITE}. Reuse existing SRAM_DATA_WIDTH and the SRAM address constant.
- One sub-module: vpu_wb_fifo. Synchronous FIFO with push/pop/occupancy/head outputs and asynchronous active-high reset. The top holds the FSM and wr_cnt.

## Test plan
- Reset: assert rst mid-run → wr_req=0, in_ready=1, idle=1, occupancy=0, wr_cnt=0 without waiting for clk.
- Single write: push addr 0x0010, data lanes all 0x3C00 with wr_ack high → wr_req high for exactly 1 cycle, starting 1 cycle after the push edge; wr_addr=0x0010; wr_cnt=1; idle=1 afterwards.
- Back-to-back: 7 pushes on consecutive cycles (addr 0..6, data = addr replicated), wr_ack always 1 → 7 contiguous wr_req cycles in order, wr_cnt=7, in_ready never low.
- Backpressure: wr_ack=0, push 5 entries → in_ready drops after the 4th. occupancy=4. The 5th is held by the producer and wr_addr is stable. Raise wr_ack → all 5 written in order, wr_cnt=5.
- Simultaneous push/pop: occupancy=2, in_valid=1 and wr_ack=1 in the same cycle → occupancy stays 2 and the next head is presented in the following cycle.
- Ack ignored/wrap: pulse wr_ack while idle → wr_cnt unchanged. Preload wr_cnt to 0xFFFF via 65535 writes, then 1 more → wr_cnt=0x0000.
